cv32e40px_x_result_buf: RTL
===========================

# cv32e40px_x_result_buf

Buffers CORE-V-XIF result-channel transactions returned by the coprocessor and retires them into the core register file write port. It arbitrates against the core's own WB-stage write and signals scoreboard clear events back to the offload dispatcher. It sits between the coprocessor result interface and the WB stage, directly downstream of the issue/commit dispatcher.

## Interface
- DEPTH, 2, number of result entries (power of two, ≥2)
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles before the buffer takes priority (1–15)
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- x_result_valid_i  in  1  coprocessor result valid
- x_result_ready_o  out  1  buffer can accept a result
- x_result_id_i  in  4  instruction id
- x_result_data_i  in  32  result data
- x_result_rd_i  in  5  destination register
- x_result_we_i  in  1  result writes rd
- core_wb_we_i  in  1  core WB stage requests the register-file write port this cycle
- stall_wb_o  out  1  core must hold its WB write (buffer has priority)
- rf_we_o  out  1  register-file write enable from buffer
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- sb_clr_valid_o  out  1  scoreboard clear pulse
- sb_clr_rd_o  out  5  register to clear in scoreboard
- last_id_o  out  4  id of most recently retired result
- empty_o  out  1  no buffered results

## Operation
- Circular FIFO of {id, data, rd, we}, DEPTH entries; write/read pointers of log2(DEPTH) bits plus occupancy counter of log2(DEPTH)+1 bits.
- Push: x_result_valid_i & x_result_ready_o. x_result_ready_o = (count != DEPTH); it depends only on registered state.
- Grant: head valid & (~core_wb_we_i | stall_wb_o). The entry is popped on grant.
- Retire on pop: rf_we_o = head.we & (head.rd != 0); rf_waddr_o/rf_wdata_o = head fields. sb_clr_valid_o = head.we; this includes rd=0, so the dispatcher clears its bit. last_id_o updates to head.id.
- Entries with we=0 pop on the first cycle the buffer is non-empty, independent of core_wb_we_i. They drive only last_id_o.
- Starvation counter (4 b): increments each cycle head valid, head.we=1, and not granted. It clears on any grant or when empty. stall_wb_o = (counter ≥ STARVE_LIMIT) & head valid.
- Simultaneous push and pop: count unchanged, both pointers advance. Push when full is impossible because ready is low; valid held by source.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (rst_ni low at posedge): pointers, count, starvation counter = 0. last_id_o = 0. x_result_ready_o = 1. empty_o = 1. All other outputs 0.
- Reset mid-operation discards all buffered entries with no clear pulses.
- Default latency: push at cycle N → earliest rf_we_o/sb_clr_valid_o at N+1, registered through the FIFO.
- Outputs rf_*, sb_clr_*, stall_wb_o are combinational from head state and core_wb_we_i. Throughput is one retire per cycle.

## Configuration
- CV32E40PX_X_RESULT_BYPASS_EN defined: when the FIFO is empty, a push with x_result_valid_i, and the port is free (~core_wb_we_i, or we=0), the result retires in the same cycle with zero latency and is not stored. In this mode, rf_*/sb_clr_* become combinational from x_result_* inputs.
- CV32E40PX_X_RESULT_BYPASS_EN undefined: no bypass path; minimum latency 1 cycle as above.

## Structure
- Entry struct typedef (id, data, rd, we) belongs in cv32e40px_core_v_xif_pkg, alongside the existing X_* constants.
- One sub-module: cv32e40px_x_result_fifo (generic storage, pointers, count), instanced once. Arbitration, starvation logic and bypass stay in the top.

## Test plan
- Single result id=3, rd=5, data=0xDEADBEEF, we=1, core_wb_we_i=0 → next cycle rf_we_o=1, addr=5, data=0xDEADBEEF, sb_clr_rd_o=5, last_id_o=3. With bypass: same values in the push cycle.
- Two back-to-back pushes with core_wb_we_i=1 held → after 2 pushes x_result_ready_o=0. The third valid is held. With STARVE_LIMIT=4, stall_wb_o rises on the 4th cycle and the head retires that cycle.
- Result rd=0, we=1 → rf_we_o=0, sb_clr_valid_o=1 with sb_clr_rd_o=0, entry popped.
- Result we=0 while core_wb_we_i=1 → pops the next cycle, rf_we_o=0, sb_clr_valid_o=0, last_id_o updated.
- Full FIFO with a simultaneous pop and new valid → ready=0 that cycle. The push is accepted the following cycle; order preserved (ids 0,1,2 retire in order).
- rst_ni low for one cycle with 2 entries buffered → next cycle empty_o=1, ready=1, no rf_we_o, no sb_clr_valid_o pulses.

Source files
------------

// File: rtl/cv32e40px_core_v_xif_pkg.sv
// CORE-V-XIF shared constants and the result-buffer entry type.
package cv32e40px_core_v_xif_pkg;

    localparam int X_ID_WIDTH  = 4;
    localparam int X_RFR_WIDTH = 32;
    localparam int X_RD_WIDTH  = 5;

    // One buffered coprocessor result, ordered {id, data, rd, we}.
    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFR_WIDTH-1:0] data;
        logic [X_RD_WIDTH-1:0]  rd;
        logic                   we;
    } x_result_entry_t;

    localparam int X_RESULT_ENTRY_W = $bits(x_result_entry_t);

    // A result touches the register file only when it writes a non-zero rd.
    function automatic logic x_result_writes_rf(input x_result_entry_t e);
        return e.we && (e.rd != '0);
    endfunction

endpackage

// File: rtl/cv32e40px_x_result_fifo.sv
// Circular FIFO holding coprocessor results: storage, read/write pointers
// and an occupancy counter. Pointers wrap naturally (DEPTH is a power of two).
module cv32e40px_x_result_fifo
    import cv32e40px_core_v_xif_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = X_RESULT_ENTRY_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = 1;
    localparam logic [PW:0]   CNT_ONE    = 1;
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    // Pointer and occupancy bookkeeping; push+pop together leave count unchanged.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates validity.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);

endmodule

// File: rtl/cv32e40px_x_result_buf.sv
// Buffers CORE-V-XIF result transactions and retires them into the register
// file write port, arbitrating against the core WB-stage write. A head that has
// lost arbitration STARVE_LIMIT cycles in a row takes priority and stalls WB.
// Optional feature macro: CV32E40PX_X_RESULT_BYPASS_EN (zero-latency retire
// of a result arriving while the buffer is empty and the port is free).
//
// Handshake: a result is accepted on a cycle where x_result_valid_i and
// x_result_ready_o are both high; ready depends only on registered occupancy,
// and the source holds valid and its payload stable until accepted.
module cv32e40px_x_result_buf
    import cv32e40px_core_v_xif_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        x_result_valid_i,
    output logic        x_result_ready_o,
    input  logic [3:0]  x_result_id_i,
    input  logic [31:0] x_result_data_i,
    input  logic [4:0]  x_result_rd_i,
    input  logic        x_result_we_i,
    input  logic        core_wb_we_i,
    output logic        stall_wb_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        sb_clr_valid_o,
    output logic [4:0]  sb_clr_rd_o,
    output logic [3:0]  last_id_o,
    output logic        empty_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    x_result_entry_t              in_entry;
    x_result_entry_t              head;
    x_result_entry_t              retire_entry;
    logic [X_RESULT_ENTRY_W-1:0]  head_bits;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic                         head_valid;
    logic                         grant;
    logic                         bypass;
    logic                         push;
    logic                         retire_valid;
    logic [3:0]                   starve_cnt;

    assign in_entry = '{id: x_result_id_i, data: x_result_data_i,
                        rd: x_result_rd_i, we: x_result_we_i};

    assign x_result_ready_o = ~fifo_full;
    assign head_valid       = ~fifo_empty;
    assign head             = x_result_entry_t'(head_bits);
    assign empty_o          = fifo_empty;

    // A starved head wins the port; we=0 entries never need the port at all.
    assign stall_wb_o = head_valid & (starve_cnt >= STARVE_LIM);
    assign grant      = head_valid & (~head.we | ~core_wb_we_i | stall_wb_o);

`ifdef CV32E40PX_X_RESULT_BYPASS_EN
    assign bypass = fifo_empty & x_result_valid_i & (~core_wb_we_i | ~x_result_we_i);
`else
    assign bypass = 1'b0;
`endif

    assign push = x_result_valid_i & x_result_ready_o & ~bypass;

    cv32e40px_x_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (X_RESULT_ENTRY_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (push),
        .push_data (in_entry),
        .pop       (grant),
        .head_data (head_bits),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Select the entry retiring this cycle: the granted head, or a bypassed input.
    always_comb begin
        retire_valid = 1'b0;
        retire_entry = '0;
        if (grant) begin
            retire_valid = 1'b1;
            retire_entry = head;
        end else if (bypass) begin
            retire_valid = 1'b1;
            retire_entry = in_entry;
        end
    end

    // Retire outputs; address/data/rd are zero whenever no write/clear occurs.
    always_comb begin
        rf_we_o        = retire_valid & x_result_writes_rf(retire_entry);
        rf_waddr_o     = rf_we_o ? retire_entry.rd : '0;
        rf_wdata_o     = rf_we_o ? retire_entry.data : '0;
        sb_clr_valid_o = retire_valid & retire_entry.we;
        sb_clr_rd_o    = sb_clr_valid_o ? retire_entry.rd : '0;
    end

    // Remember the id of the most recently retired result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_id_o <= '0;
        end else if (retire_valid) begin
            last_id_o <= retire_entry.id;
        end
    end

    // Count consecutive cycles a writing head has lost the port.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (grant || !head_valid) begin
            starve_cnt <= '0;
        end else if (head.we && starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule
